// File: rtl/bldc_pkg.sv
// Hall code constants and sequence helpers shared by the Hall front-end and the commutator.
package bldc_pkg;

    localparam logic [2:0] H001     = 3'b001;
    localparam logic [2:0] H101     = 3'b101;
    localparam logic [2:0] H100     = 3'b100;
    localparam logic [2:0] H110     = 3'b110;
    localparam logic [2:0] H010     = 3'b010;
    localparam logic [2:0] H011     = 3'b011;
    localparam logic [2:0] HALL_RST = 3'b001;

    // Forward rotation order: 001 -> 101 -> 100 -> 110 -> 010 -> 011 -> 001.
    function automatic logic [2:0] hall_next(input logic [2:0] code);
        case (code)
            H001:    return H101;
            H101:    return H100;
            H100:    return H110;
            H110:    return H010;
            H010:    return H011;
            H011:    return H001;
            default: return code;
        endcase
    endfunction

    function automatic logic [2:0] hall_prev(input logic [2:0] code);
        case (code)
            H001:    return H011;
            H011:    return H010;
            H010:    return H110;
            H110:    return H100;
            H100:    return H101;
            H101:    return H001;
            default: return code;
        endcase
    endfunction

    function automatic logic hall_legal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// 2-FF synchroniser plus stability counter; emits a registered one-shot acceptance strobe.
// Latency: FILT_LEN+2 edges from first sample to strobe; no backpressure.
module hall_glitch_filter
    import bldc_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] raw_i,
    input  logic [2:0] hall_i,
    output logic       acc_vld_o,
    output logic [2:0] acc_dat_o
);

    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [2:0]       s1_q, s2_q;
    logic [2:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic             acc_vld_q, acc_vld_d;
    logic [2:0]       acc_dat_q;

    // fired_q makes acceptance one-shot per candidate, so a stable illegal code reports once.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        fired_d   = fired_q;
        acc_vld_d = 1'b0;
        if (s2_q != cand_q) begin
            cand_d  = s2_q;
            cnt_d   = '0;
            fired_d = 1'b0;
        end else begin
            if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q == CNT_LAST) && (cand_q != hall_i) && !fired_q) begin
                acc_vld_d = 1'b1;
                fired_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= HALL_RST;
            s2_q      <= HALL_RST;
            cand_q    <= HALL_RST;
            cnt_q     <= '0;
            fired_q   <= 1'b0;
            acc_vld_q <= 1'b0;
            acc_dat_q <= HALL_RST;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            fired_q   <= fired_d;
            acc_vld_q <= acc_vld_d;
            acc_dat_q <= cand_q;
        end
    end

    assign acc_vld_o = acc_vld_q;
    assign acc_dat_o = acc_dat_q;

endmodule

// File: rtl/hall_conditioner.sv
// Hall front-end: filtered legal code, step/dir, period and stall; HALL_POS_CNT_EN adds a signed position count.
// Latency: raw change to hall/step is FILT_LEN+3 edges; all outputs registered, no backpressure.
module hall_conditioner
    import bldc_pkg::*;
#(
    parameter int FILT_LEN  = 4,
    parameter int PER_W     = 16,
    parameter int STALL_CYC = 50000
`ifdef HALL_POS_CNT_EN
    ,
    parameter int POS_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_u,
    input  logic             raw_v,
    input  logic             raw_w,
    output logic             hall_u,
    output logic             hall_v,
    output logic             hall_w,
    output logic             step,
    output logic             dir,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             stall,
    output logic             code_err,
    output logic             skip_err
`ifdef HALL_POS_CNT_EN
    ,
    output logic signed [POS_W-1:0] pos
`endif
);

    localparam logic [PER_W-1:0] PER_MAX  = {PER_W{1'b1}};
    localparam logic [PER_W-1:0] STALL_TH = PER_W'(STALL_CYC);

    logic             acc_vld;
    logic [2:0]       acc_dat;
    logic             acc_legal, is_fwd, is_rev, is_step;

    logic [2:0]       hall_q, hall_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             period_vld_q, period_vld_d;
    logic             stall_q, stall_d;
    logic             code_err_q, code_err_d;
    logic             skip_err_q, skip_err_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic             ref_q, ref_d;

    hall_glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk       (clk),
        .reset     (reset),
        .raw_i     ({raw_u, raw_v, raw_w}),
        .hall_i    (hall_q),
        .acc_vld_o (acc_vld),
        .acc_dat_o (acc_dat)
    );

    assign acc_legal = hall_legal(acc_dat);
    assign is_fwd    = acc_vld && acc_legal && (acc_dat == hall_next(hall_q));
    assign is_rev    = acc_vld && acc_legal && (acc_dat == hall_prev(hall_q));
    assign is_step   = is_fwd || is_rev;

    // ref_q: a previous step exists that a new same-direction step may be timed against.
    always_comb begin
        hall_d       = hall_q;
        step_d       = 1'b0;
        dir_d        = dir_q;
        period_d     = period_q;
        period_vld_d = period_vld_q;
        stall_d      = stall_q;
        code_err_d   = 1'b0;
        skip_err_d   = 1'b0;
        ref_d        = ref_q;
        per_cnt_d    = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PER_W'(1);
        if (acc_vld) begin
            if (!acc_legal) begin
                code_err_d = 1'b1;
            end else if (is_step) begin
                hall_d    = acc_dat;
                step_d    = 1'b1;
                dir_d     = is_fwd;
                per_cnt_d = PER_W'(1);
                stall_d   = 1'b0;
                ref_d     = 1'b1;
                if (ref_q && !stall_q && (dir_q == is_fwd)) begin
                    period_d     = per_cnt_q;
                    period_vld_d = 1'b1;
                end else begin
                    period_vld_d = 1'b0;
                end
            end else if (acc_dat != hall_q) begin
                hall_d       = acc_dat;
                skip_err_d   = 1'b1;
                period_vld_d = 1'b0;
                per_cnt_d    = '0;
                ref_d        = 1'b0;
            end
        end
        if (!is_step && (per_cnt_q == STALL_TH)) begin
            stall_d      = 1'b1;
            period_vld_d = 1'b0;
            ref_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hall_q       <= HALL_RST;
            step_q       <= 1'b0;
            dir_q        <= 1'b1;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            stall_q      <= 1'b0;
            code_err_q   <= 1'b0;
            skip_err_q   <= 1'b0;
            per_cnt_q    <= '0;
            ref_q        <= 1'b0;
        end else begin
            hall_q       <= hall_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            stall_q      <= stall_d;
            code_err_q   <= code_err_d;
            skip_err_q   <= skip_err_d;
            per_cnt_q    <= per_cnt_d;
            ref_q        <= ref_d;
        end
    end

`ifdef HALL_POS_CNT_EN
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (is_fwd)      pos_d = pos_q + POS_W'(1);
        else if (is_rev) pos_d = pos_q - POS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) pos_q <= '0;
        else       pos_q <= pos_d;
    end

    assign pos = pos_q;
`endif

    assign {hall_u, hall_v, hall_w} = hall_q;
    assign step       = step_q;
    assign dir        = dir_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign stall      = stall_q;
    assign code_err   = code_err_q;
    assign skip_err   = skip_err_q;

endmodule
